// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC generation, ibus request issue, 64-bit response split
// into tagged 32-bit instructions, and an instruction FIFO that presents up to
// two instructions per cycle to decode.
//   clk, reset          clock, synchronous active-high reset
//   flush, flush_pc     backend redirect pulse and target
//   ireq_valid/addr     request to the instruction cache
//   iresp_addr_ok       cache accepted the request this cycle
//   iresp_data_ok/data  response beat (two words of the 8-byte block)
//   out_valid/inst/pc   FIFO head and head+1 presented to decode
//   deq_num             instructions consumed by decode this cycle
module fetch_queue #(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] PC_RESET        = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [63:0] iresp_data,
  output logic [1:0]  out_valid,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  input  logic [1:0]  deq_num
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [SW-1:0] srd_q, srd_d, swr_q, swr_d;

  // Side FIFO: per-request PC (bit 2 doubles as the single-word flag).
  logic [31:0] side_pc_q [MAX_OUTSTANDING];
  logic        side_s_q  [MAX_OUTSTANDING];

  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  logic        accept, space_ok, resp_s;
  logic [31:0] resp_pc;
  logic        wr0_en, wr1_en;
  logic [31:0] wr0_inst, wr0_pc, wr1_inst, wr1_pc;
  logic [1:0]  n_wr;
  logic [AW-1:0] head1;
  logic        unused_flush_lsb;

  assign unused_flush_lsb = &{1'b0, flush_pc[1:0]};

  function automatic logic [SW-1:0] side_next(input logic [SW-1:0] p);
    return (p == SW'(MAX_OUTSTANDING - 1)) ? '0 : p + SW'(1);
  endfunction

  // Reserve room for two words per in-flight request plus the new one so
  // that a response can always be written.
  assign space_ok   = (32'(count_q) + 32'd2 * (32'(outst_q) + 32'd1)) <= 32'(DEPTH);
  assign ireq_valid = !reset && !flush && (outst_q < OW'(MAX_OUTSTANDING)) && space_ok;
  assign ireq_addr  = pc_q;
  assign accept     = ireq_valid && iresp_addr_ok;

  assign resp_s  = side_s_q[srd_q];
  assign resp_pc = side_pc_q[srd_q];

  assign head1     = head_q + AW'(1);
  assign out_valid = reset ? 2'b00 : {count_q >= CW'(2), count_q >= CW'(1)};
  assign out_inst0 = inst_mem_q[head_q];
  assign out_pc0   = pc_mem_q[head_q];
  assign out_inst1 = inst_mem_q[head1];
  assign out_pc1   = pc_mem_q[head1];

  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    outst_d   = outst_q + OW'(accept) - OW'(iresp_data_ok);
    discard_d = discard_q;
    srd_d     = srd_q;
    swr_d     = swr_q;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    wr0_inst  = resp_s ? iresp_data[63:32] : iresp_data[31:0];
    wr0_pc    = resp_pc;
    wr1_inst  = iresp_data[63:32];
    wr1_pc    = resp_pc + 32'd4;
    n_wr      = 2'd0;

    if (accept) begin
      pc_d  = {pc_q[31:3] + 29'd1, 3'b000};
      swr_d = side_next(swr_q);
    end

    if (iresp_data_ok) begin
      srd_d = side_next(srd_q);
      if (discard_q != '0) begin
        discard_d = discard_q - OW'(1);
      end else begin
        wr0_en = 1'b1;
        wr1_en = !resp_s;
        n_wr   = resp_s ? 2'd1 : 2'd2;
      end
    end

    head_d  = head_q + AW'(deq_num);
    tail_d  = tail_q + AW'(n_wr);
    count_d = count_q + CW'(n_wr) - CW'(deq_num);

    // Redirect: the side FIFO keeps tracking in-flight requests; their
    // responses are dropped via discard instead of being written.
    if (flush) begin
      pc_d      = {flush_pc[31:2], 2'b00};
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      discard_d = outst_d;
      wr0_en    = 1'b0;
      wr1_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      srd_q     <= '0;
      swr_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      srd_q     <= srd_d;
      swr_q     <= swr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      side_pc_q[swr_q] <= pc_q;
      side_s_q[swr_q]  <= pc_q[2];
    end
    if (!reset && wr0_en) begin
      inst_mem_q[tail_q] <= wr0_inst;
      pc_mem_q[tail_q]   <= wr0_pc;
    end
    if (!reset && wr1_en) begin
      inst_mem_q[tail_q + AW'(1)] <= wr1_inst;
      pc_mem_q[tail_q + AW'(1)]   <= wr1_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !flush |-> (32'(count_q) + 32'(n_wr) <= 32'(DEPTH) + 32'(deq_num)));
  a_deq_legal: assert property (@(posedge clk) disable iff (reset)
    32'(deq_num) <= 32'(out_valid[0]) + 32'(out_valid[1]));
  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
    iresp_data_ok |-> (outst_q != '0));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch-side stage upstream and downstream of the instruction cache.
- Generates the fetch PC and issues 8-byte-aligned requests on the cache's ibus request side.
- Accepts the 64-bit response beats and splits them into 32-bit instructions tagged with their PC.
- Buffers the instructions in a FIFO and delivers up to two per cycle to decode; supports redirect (flush) with discard of in-flight responses.

Parameters:
- DEPTH, 16: instruction FIFO entries (power of 2, ≥4).
- MAX_OUTSTANDING, 2: maximum requests accepted by the cache (addr_ok seen) and not yet answered (data_ok).
- PC_RESET, 32'hbfc0_0000: fetch PC after reset.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  redirect pulse from the backend.
- flush_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  32  fetch address, equal to the current PC.
- iresp_addr_ok  in  1  cache accepted the request this cycle.
- iresp_data_ok  in  1  response beat valid.
- iresp_data  in  64  response: [31:0] is the word at addr&~7, [63:32] is the word at (addr&~7)+4.
- out_valid  out  2  bit i set means slot i holds a valid instruction; legal values are 00, 01, 11.
- out_inst0, out_inst1  out  32  FIFO head and head+1 instructions.
- out_pc0, out_pc1  out  32  PCs of those instructions.
- deq_num  in  2  instructions consumed this cycle (0..2); must be ≤ popcount(out_valid).

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - pc=PC_RESET; FIFO count=0, head=tail=0; outstanding=0; discard=0; side FIFO empty.
  - During and after reset the outputs are ireq_valid=0 and out_valid=00.
- Issue:
  - ireq_valid = !reset && !flush && outstanding<MAX_OUTSTANDING && (count + 2*(outstanding+1)) ≤ DEPTH. This space reservation guarantees a response is never dropped for lack of space.
  - ireq_addr=pc. It is held stable while ireq_valid=1 and addr_ok=0.
  - On ireq_valid && addr_ok: outstanding+1; pc[2] is pushed into an MAX_OUTSTANDING-deep side FIFO; pc <= {pc[31:3]+1, 3'b000}.
- Response:
  - On data_ok, pop the side FIFO to obtain bit s.
  - If discard>0: decrement discard; no FIFO write.
  - Otherwise, if s=0: write two entries, {data[31:0], A} then {data[63:32], A+4}, where A is the request PC.
  - Otherwise (s=1): write one entry, {data[63:32], A}.
  - Entry PCs are reconstructed from a registered per-request PC, also stored in the side FIFO. The side FIFO is therefore 33 bits wide: 32-bit PC plus the s bit.
  - outstanding-1 on every data_ok.
- Simultaneous addr_ok and data_ok in the same cycle: outstanding is unchanged; the side FIFO pushes and pops in the same cycle.
- Dequeue:
  - out slot 0 = entry at head; slot 1 = entry at head+1 mod DEPTH.
  - out_valid = {count≥2, count≥1}.
  - head += deq_num with mod-DEPTH wrap; count += writes − deq_num in the same cycle.
- Flush (flush=1 at posedge; takes priority over everything except reset):
  - pc <= {flush_pc[31:2], 2'b00}; FIFO emptied; same-cycle dequeue and writes ignored.
  - discard <= (outstanding after applying this cycle's addr_ok and data_ok events).
  - A request accepted in the flush cycle is impossible, since ireq_valid=0 while flush=1.
  - A data_ok in the flush cycle is dropped and counted.
  - out_valid=00 from the next cycle until new data arrives.
  - After flush, new responses are accepted only once discard reaches 0; the cache returns responses in order.
- Flush to a PC with bit 2 set: the first request yields one instruction. Subsequent requests are aligned and yield two.
- Full: when count+2*(outstanding+1) > DEPTH, no issue. The FIFO never overflows; overflow is an assertion.
- Illegal deq_num > popcount(out_valid) is an assertion.
- Latency: addr_ok at cycle T with data_ok at T+1 gives out_valid at T+2 (one registered FIFO write). No same-cycle bypass from the response to the outputs.

Test Plan:
- Reset then a cache model with addr_ok=1 always and data_ok one cycle later, data 64'h22222222_11111111: out_pc0=bfc00000/inst0=11111111, out_pc1=bfc00004/inst1=22222222; the next request goes to bfc00008.
- flush_pc=0x80000004: first request addr 80000004 yields a single entry {inst=data[63:32], pc 80000004}; the next request goes to 80000008 with two entries.
- deq_num=0 held: issue stops once count+2*(outstanding+1)>16. Count reaches exactly 16, no overflow, ireq_valid=0; deq_num=2 for one cycle re-enables issue when space allows.
- Flush with 2 outstanding and one data_ok in the same cycle: discard=1. The next data_ok is dropped; FIFO stays empty until the first post-flush response, which carries PCs from flush_pc.
- Wrap: with DEPTH=16, alternate deq_num=1/2 for 40 instructions; the PC sequence stays contiguous (+4) across pointer wrap, and out_valid=01 is seen whenever count=1.
- Reset asserted mid-burst with outstanding=2: the next cycle has ireq_valid=0, out_valid=00, and pc=PC_RESET after reset deasserts.
